// File: rtl/car_state_keeper_if.sv
// Decoder-side and display-side signals of the car state keeper.
// The decoder/display side takes the master view, the keeper the slave view.
interface car_state_keeper_if #(
    parameter int MILE_W = 24
);
    logic [1:0]        next_state;
    logic [3:0]        next_moving_state;
    logic              next_power;
    logic [5:0]        ctrl;
    logic [1:0]        state;
    logic [3:0]        moving_state;
    logic              power;
    logic [MILE_W-1:0] mileage;
    logic              auto_off;
    logic [3:0]        idle_sec;

    modport master (
        output next_state, next_moving_state, next_power, ctrl,
        input  state, moving_state, power, mileage, auto_off, idle_sec
    );

    modport slave (
        input  next_state, next_moving_state, next_power, ctrl,
        output state, moving_state, power, mileage, auto_off, idle_sec
    );
endinterface

// File: rtl/car_state_keeper.sv
// Holds the car's registered state fed back to the manual-drive decoder,
// with an idle auto power-off timer and a moving-time odometer.
module car_state_keeper #(
    parameter int TICK_DIV = 100000,
    parameter int IDLE_MS  = 10000,
    parameter int MILE_MS  = 1000,
    parameter int MILE_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    car_state_keeper_if.slave bus
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDLE_W  = $clog2(IDLE_MS + 1);
    localparam int MCNT_W  = (MILE_MS > 1) ? $clog2(MILE_MS) : 1;

    localparam logic [1:0] ST_NSTART = 2'b00;
    localparam logic [1:0] ST_MOVING = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;
    localparam logic [3:0] MV_NONE   = 4'b0000;
    localparam logic [3:0] SEC_MAX   = 4'd15;

    function automatic logic [MILE_W-1:0] sat_inc(input logic [MILE_W-1:0] v);
        return (&v) ? v : v + MILE_W'(1);
    endfunction

    // Whole seconds left before auto-off, clamped to what the 4-bit display can show.
    function automatic logic [3:0] sec_left(input logic [IDLE_W-1:0] cnt);
        int unsigned secs;
        secs = (int'(IDLE_MS) - int'(cnt)) / 1000;
        return (secs > 15) ? SEC_MAX : 4'(secs);
    endfunction

    logic [PRESC_W-1:0] presc;
    logic [5:0]         ctrl_q;
    logic               lock;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [MCNT_W-1:0]  mile_cnt;
    logic [1:0]         state_q;
    logic [3:0]         mstate_q;
    logic               power_q;
    logic [MILE_W-1:0]  mileage_q;
    logic               auto_off_q;
    logic [3:0]         idle_sec_q;

    logic               tick;
    logic               act;
    logic               is_moving;
    logic               fire;
    logic               power_d;
    logic [1:0]         state_d;
    logic [3:0]         mstate_d;
    logic [IDLE_W-1:0]  idle_d;
    logic [3:0]         idle_sec_d;
    logic               lock_d;
    logic               in_window;
    logic               mile_step;
    logic               mile_wrap;

    always_comb begin
        tick      = (presc == PRESC_W'(TICK_DIV - 1));
        act       = (bus.ctrl != ctrl_q);
        is_moving = (state_q == ST_MOVING);
        // Any control activity in the final tick cycle cancels the power-off.
        fire      = tick & (idle_cnt == IDLE_W'(IDLE_MS - 1)) & power_q & ~is_moving & ~act;

        power_d  = bus.next_power & ~lock & ~fire;
        state_d  = ST_NSTART;
        mstate_d = MV_NONE;
        if (power_d) begin
            state_d  = (bus.next_state == ST_ILLEGAL) ? ST_NSTART : bus.next_state;
            mstate_d = bus.next_moving_state;
        end

        if (~power_q | is_moving | act | fire) begin
            idle_d = '0;
        end else if (tick) begin
            idle_d = idle_cnt + IDLE_W'(1);
        end else begin
            idle_d = idle_cnt;
        end

        // idle_sec is registered alongside the state it describes.
        idle_sec_d = (power_d && state_d != ST_MOVING) ? sec_left(idle_d) : SEC_MAX;

        // A lock set by the timeout only clears once the request is seen low.
        if (fire) begin
            lock_d = 1'b1;
        end else if (!bus.next_power) begin
            lock_d = 1'b0;
        end else begin
            lock_d = lock;
        end

        in_window = power_q & is_moving & (mstate_q != MV_NONE);
        mile_step = in_window & tick;
        mile_wrap = mile_step & (mile_cnt == MCNT_W'(MILE_MS - 1));
    end

    // ms prescaler, free running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // car state registration and idle timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            lock       <= 1'b0;
            idle_cnt   <= '0;
            power_q    <= 1'b0;
            state_q    <= ST_NSTART;
            mstate_q   <= MV_NONE;
            auto_off_q <= 1'b0;
            idle_sec_q <= SEC_MAX;
        end else begin
            ctrl_q     <= bus.ctrl;
            lock       <= lock_d;
            idle_cnt   <= idle_d;
            power_q    <= power_d;
            state_q    <= state_d;
            mstate_q   <= mstate_d;
            auto_off_q <= fire;
            idle_sec_q <= idle_sec_d;
        end
    end

    // odometer; the partial ms count survives leaving the moving window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mile_cnt  <= '0;
            mileage_q <= '0;
        end else if (mile_wrap) begin
            mile_cnt  <= '0;
            mileage_q <= sat_inc(mileage_q);
        end else if (mile_step) begin
            mile_cnt  <= mile_cnt + MCNT_W'(1);
        end
    end

    assign bus.state        = state_q;
    assign bus.moving_state = mstate_q;
    assign bus.power        = power_q;
    assign bus.mileage      = mileage_q;
    assign bus.auto_off     = auto_off_q;
    assign bus.idle_sec     = idle_sec_q;

endmodule

// File: tb/tb_car_state_keeper.sv
// Randomized and directed bench for car_state_keeper against a behavioural model.
module tb_car_state_keeper;

    localparam int TD = 4;
    localparam int IM = 10;
    localparam int MM = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       np  = 1'b0;
    logic [1:0] ns  = 2'b00;
    logic [3:0] nms = 4'b0000;
    logic [5:0] c   = 6'b0;

    always #5 clk = ~clk;

    car_state_keeper_if #(.MILE_W(24)) bus_a ();
    car_state_keeper_if #(.MILE_W(2))  bus_b ();

    assign bus_a.next_power = np;
    assign bus_a.next_state = ns;
    assign bus_a.next_moving_state = nms;
    assign bus_a.ctrl = c;
    assign bus_b.next_power = np;
    assign bus_b.next_state = ns;
    assign bus_b.next_moving_state = nms;
    assign bus_b.ctrl = c;

    car_state_keeper #(.TICK_DIV(TD), .IDLE_MS(IM), .MILE_MS(MM), .MILE_W(24)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    car_state_keeper #(.TICK_DIV(TD), .IDLE_MS(IM), .MILE_MS(MM), .MILE_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // behavioural model: elapsed-time bookkeeping in ms
    bit         m_power, m_lock, m_auto;
    logic [1:0] m_state;
    logic [3:0] m_ms;
    int         m_idle;
    longint     m_moving_ms;
    logic [5:0] m_ctrl_prev;
    longint     m_cyc;

    task automatic model_reset();
        m_power = 0; m_lock = 0; m_auto = 0;
        m_state = 2'b00; m_ms = 4'b0000;
        m_idle = 0; m_moving_ms = 0; m_ctrl_prev = 6'b0; m_cyc = 0;
    endtask

    task automatic model_step();
        bit tick, act, moving, fire, pw;
        tick   = (m_cyc % TD) == TD - 1;
        act    = (c != m_ctrl_prev);
        moving = m_power && (m_state == 2'b10);
        fire   = tick && m_power && !moving && !act && (m_idle == IM - 1);
        if (moving && m_ms != 4'b0000 && tick) m_moving_ms++;
        if (!m_power || moving || act || fire) m_idle = 0;
        else if (tick) m_idle++;
        pw = np && !m_lock && !fire;
        if (fire) m_lock = 1;
        else if (!np) m_lock = 0;
        m_auto  = fire;
        m_power = pw;
        m_state = pw ? ((ns == 2'b11) ? 2'b00 : ns) : 2'b00;
        m_ms    = pw ? nms : 4'b0000;
        m_ctrl_prev = c;
        m_cyc++;
    endtask

    function automatic longint exp_idle_sec();
        longint s;
        if (m_power && m_state != 2'b10) begin
            s = (IM - m_idle) / 1000;
            return (s > 15) ? 15 : s;
        end
        return 15;
    endfunction

    function automatic longint exp_miles(input longint maxv);
        longint v;
        v = m_moving_ms / MM;
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".power"},    bus_a.power,        m_power);
        chk({tag, ".state"},    bus_a.state,        m_state);
        chk({tag, ".mstate"},   bus_a.moving_state, m_ms);
        chk({tag, ".auto_off"}, bus_a.auto_off,     m_auto);
        chk({tag, ".idle_sec"}, bus_a.idle_sec,     exp_idle_sec());
        chk({tag, ".mileage"},  bus_a.mileage,      exp_miles(64'hFFFFFF));
        chk({tag, ".mileage2"}, bus_b.mileage,      exp_miles(3));
    endtask

    task automatic cycle(input logic p, input logic [1:0] s, input logic [3:0] m, input logic [5:0] k);
        np = p; ns = s; nms = m; c = k;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int pulses;
    int pulse_at;

    initial begin
        // 1: reset with an active request, then release
        np = 1; ns = 2'b10; nms = 4'b0001;
        do_reset();
        chk("rst_idle_sec", bus_a.idle_sec, 4'd15);
        chk("rst_power", bus_a.power, 1'b0);
        cycle(1, 2'b10, 4'b0001, 6'h0);
        chk("first_power", bus_a.power, 1'b1);
        chk("first_state", bus_a.state, 2'b10);

        // 2: idle timeout and lock
        do_reset();
        pulses = 0; pulse_at = -1;
        for (int i = 0; i < 60; i++) begin
            cycle(1, 2'b01, 4'b0000, 6'h0);
            if (bus_a.auto_off) begin
                pulses++;
                pulse_at = i;
                chk("off_power", bus_a.power, 1'b0);
                chk("off_state", bus_a.state, 2'b00);
            end
        end
        chk("auto_off_pulses", pulses, 1);
        chk("auto_off_cycle", pulse_at, 39);
        chk("locked_power", bus_a.power, 1'b0);
        cycle(0, 2'b01, 4'b0000, 6'h0);
        cycle(1, 2'b01, 4'b0000, 6'h0);
        chk("repower", bus_a.power, 1'b1);

        // 3: activity just before the timeout restarts the idle count
        do_reset();
        pulses = 0;
        for (int i = 0; i < 44; i++) begin
            cycle(1, 2'b01, 4'b0000, (i >= 36) ? 6'h1 : 6'h0);
            if (bus_a.auto_off) pulses++;
        end
        chk("act_cancel_pulses", pulses, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 2'b01, 4'b0000, 6'h1);
            if (bus_a.auto_off) pulses++;
        end
        chk("restart_pulses", pulses, 1);

        // 4: odometer
        do_reset();
        for (int i = 0; i < 80; i++) cycle(1, 2'b10, 4'b0001, 6'h0);
        chk("miles_20ms", bus_a.mileage, 4);
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1, 2'b10, 4'b0001, 6'h0);
        for (int i = 0; i < 40; i++) cycle(1, 2'b10, 4'b0000, 6'h0);
        for (int i = 0; i < 8; i++)  cycle(1, 2'b10, 4'b0001, 6'h0);
        chk("miles_partial", bus_a.mileage, 1);

        // 5: saturation on the narrow odometer
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1, 2'b10, 4'b0010, 6'h0);
        chk("miles_sat", bus_b.mileage, 3);
        chk("miles_wide", bus_a.mileage, 5);

        // 6: illegal state and asynchronous reset mid-move
        cycle(1, 2'b11, 4'b0001, 6'h0);
        chk("illegal_state", bus_a.state, 2'b00);
        for (int i = 0; i < 30; i++) cycle(1, 2'b10, 4'b1000, 6'h0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_mileage", bus_a.mileage, 0);
        chk("async_power", bus_a.power, 0);
        check_all("async");
        @(negedge clk);
        rst = 1'b1;

        // random traffic
        begin
            logic [1:0] rs;
            logic [3:0] rm;
            logic [5:0] rc;
            logic       rp;
            rs = 2'b01; rm = 4'b0000; rc = 6'h0; rp = 1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 31) == 0) rs = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 4))
                        0: rm = 4'b0000;
                        1: rm = 4'b0001;
                        2: rm = 4'b0010;
                        3: rm = 4'b0100;
                        default: rm = 4'b1000;
                    endcase
                end
                if ($urandom_range(0, 47) == 0) rc = rc ^ (6'b1 << $urandom_range(0, 5));
                if ($urandom_range(0, 19) == 0) rp = ~rp;
                cycle(rp, rs, rm, rc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
